alu_op_sequencer: RTL and testbench

//  Multi-cycle issuing master for the 32-bit ALU: accepts one MIPS instruction plus register operands over a valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Multi-cycle issuing master for the 32-bit ALU. Accepts one
//               MIPS instruction plus register operands, decodes it to
//               ALUctr, drives the ALU for EXEC_CYCLES cycles, then presents
//               the captured result over a valid/ready handshake.
//               Optional feature macro: ALU_SEQ_OVF_TRAP_EN (overflow trap on
//               add/addi/sub; suppresses writeback when set).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      rs_data_i,
  input  logic [31:0]      rt_data_i,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  output logic [2:0]       alu_ctr_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_zero_i,
  input  logic             alu_overflow_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic [4:0]       res_rd_o,
  output logic             res_we_o,
  output logic             res_zero_o,
  output logic             res_illegal_o,
  output logic             res_trap_o,
  output logic [CNT_W-1:0] op_cnt_o
);

`ifdef ALU_SEQ_OVF_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  // Countdown reload: the EXEC state lasts EXEC_CYCLES cycles.
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  localparam logic [2:0] CTR_ADDU = 3'b000;
  localparam logic [2:0] CTR_ADD  = 3'b001;
  localparam logic [2:0] CTR_OR   = 3'b010;
  localparam logic [2:0] CTR_SUBU = 3'b100;
  localparam logic [2:0] CTR_SUB  = 3'b101;
  localparam logic [2:0] CTR_SLTU = 3'b110;
  localparam logic [2:0] CTR_SLT  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Decode results
  logic [2:0]  dec_ctr;
  logic [31:0] dec_b;
  logic [4:0]  dec_rd;
  logic        dec_illegal;
  logic        dec_we;
  logic        dec_ovf;

  // Handshake/sequencing strobes
  logic accept;
  logic capture;
  logic retire;
  logic trap;

  // Latched operation context
  logic [3:0]       cnt_q;
  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic [2:0]       alu_ctr_q;
  logic [4:0]       rd_q;
  logic             we_q;
  logic             ovf_q;

  // Result registers
  logic [31:0]      res_data_q;
  logic [4:0]       res_rd_q;
  logic             res_we_q;
  logic             res_zero_q;
  logic             res_illegal_q;
  logic             res_trap_q;
  logic [CNT_W-1:0] op_cnt_q;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign opcode   = instr_i[31:26];
  assign funct    = instr_i[5:0];
  assign imm_sext = {{16{instr_i[15]}}, instr_i[15:0]};
  assign imm_zext = {16'h0000, instr_i[15:0]};

  // Register-number fields that are not needed: operands arrive pre-read.
  logic unused_fields;
  assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

  // Instruction decode: ALUctr, operand B, destination and writeback intent.
  always_comb begin
    dec_ctr     = CTR_ADDU;
    dec_b       = rt_data_i;
    dec_rd      = 5'd0;
    dec_illegal = 1'b0;
    dec_we      = 1'b0;
    dec_ovf     = 1'b0;
    case (opcode)
      6'b000000: begin
        dec_rd = instr_i[15:11];
        dec_we = (instr_i[15:11] != 5'd0);
        case (funct)
          6'b100000: begin dec_ctr = CTR_ADD; dec_ovf = 1'b1; end
          6'b100001: dec_ctr = CTR_ADDU;
          6'b100010: begin dec_ctr = CTR_SUB; dec_ovf = 1'b1; end
          6'b100011: dec_ctr = CTR_SUBU;
          6'b100101: dec_ctr = CTR_OR;
          6'b101010: dec_ctr = CTR_SLT;
          6'b101011: dec_ctr = CTR_SLTU;
          default:   begin dec_illegal = 1'b1; dec_we = 1'b0; dec_rd = 5'd0; end
        endcase
      end
      6'b001000: begin dec_ctr = CTR_ADD;  dec_b = imm_sext; dec_ovf = 1'b1; end
      6'b001001: begin dec_ctr = CTR_ADDU; dec_b = imm_sext; end
      6'b001010: begin dec_ctr = CTR_SLT;  dec_b = imm_sext; end
      6'b001011: begin dec_ctr = CTR_SLTU; dec_b = imm_sext; end
      6'b001101: begin dec_ctr = CTR_OR;   dec_b = imm_zext; end
      6'b000100: dec_ctr = CTR_SUBU;
      default:   dec_illegal = 1'b1;
    endcase
    // I-type ops write rt; beq and illegal ops never write back.
    if (opcode[5:3] == 3'b001 && !dec_illegal) begin
      dec_rd = instr_i[20:16];
      dec_we = (instr_i[20:16] != 5'd0);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid_i) begin
          accept  = 1'b1;
          state_d = dec_illegal ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready_i) begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Overflow trap only for signed add/sub forms, and only when compiled in.
  assign trap = TRAP_EN & ovf_q & alu_overflow_i;

  // Operation context: ALU drive registers and EXEC countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      alu_a_q   <= 32'd0;
      alu_b_q   <= 32'd0;
      alu_ctr_q <= 3'd0;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept && !dec_illegal) begin
      cnt_q     <= EXEC_LOAD;
      alu_a_q   <= rs_data_i;
      alu_b_q   <= dec_b;
      alu_ctr_q <= dec_ctr;
      rd_q      <= dec_rd;
      we_q      <= dec_we;
      ovf_q     <= dec_ovf;
    end else if (state_q == S_EXEC && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Result capture: ALU sample at end of EXEC, or an immediate illegal report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_q    <= 32'd0;
      res_rd_q      <= 5'd0;
      res_we_q      <= 1'b0;
      res_zero_q    <= 1'b0;
      res_illegal_q <= 1'b0;
      res_trap_q    <= 1'b0;
    end else if (accept && dec_illegal) begin
      res_data_q    <= 32'd0;
      res_rd_q      <= 5'd0;
      res_we_q      <= 1'b0;
      res_zero_q    <= 1'b0;
      res_illegal_q <= 1'b1;
      res_trap_q    <= 1'b0;
    end else if (capture) begin
      res_data_q    <= alu_result_i;
      res_rd_q      <= rd_q;
      res_we_q      <= we_q & ~trap;
      res_zero_q    <= alu_zero_i;
      res_illegal_q <= 1'b0;
      res_trap_q    <= trap;
    end
  end

  // Retired-op counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         op_cnt_q <= '0;
    else if (retire) op_cnt_q <= op_cnt_q + CNT_W'(1);
  end

  assign instr_ready_o = (state_q == S_IDLE) & ~rst;
  assign res_valid_o   = (state_q == S_DONE);
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_ctr_o     = alu_ctr_q;
  assign res_data_o    = res_data_q;
  assign res_rd_o      = res_rd_q;
  assign res_we_o      = res_we_q;
  assign res_zero_o    = res_zero_q;
  assign res_illegal_o = res_illegal_q;
  assign res_trap_o    = res_trap_q;
  assign op_cnt_o      = op_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer with an ALU stub and
//               an instruction-semantics reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  localparam int E  = 3;
  localparam int CW = 4;

`ifdef ALU_SEQ_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [31:0]   instr = '0;
  logic [31:0]   rs_data = '0;
  logic [31:0]   rt_data = '0;
  logic [31:0]   alu_a, alu_b;
  logic [2:0]    alu_ctr;
  logic [31:0]   alu_result;
  logic          alu_zero, alu_overflow;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_data;
  logic [4:0]    res_rd;
  logic          res_we, res_zero, res_illegal, res_trap;
  logic [CW-1:0] op_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.EXEC_CYCLES(E), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .instr_i(instr), .rs_data_i(rs_data), .rt_data_i(rt_data),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctr_o(alu_ctr),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero), .alu_overflow_i(alu_overflow),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_rd_o(res_rd), .res_we_o(res_we),
    .res_zero_o(res_zero), .res_illegal_o(res_illegal), .res_trap_o(res_trap),
    .op_cnt_o(op_cnt)
  );

  // ALU stub: behavioural 32-bit ALU driven by the DUT.
  function automatic logic [32:0] alu_fn(input logic [31:0] a, b, input logic [2:0] c);
    longint s;
    logic [31:0] r;
    logic v;
    r = 32'd0;
    v = 1'b0;
    case (c)
      3'b000: r = a + b;
      3'b001: begin s = longint'($signed(a)) + longint'($signed(b)); r = s[31:0]; v = (s > MAXI) || (s < MINI); end
      3'b010: r = a | b;
      3'b100: r = a - b;
      3'b101: begin s = longint'($signed(a)) - longint'($signed(b)); r = s[31:0]; v = (s > MAXI) || (s < MINI); end
      3'b110: r = (a < b) ? 32'd1 : 32'd0;
      3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {v, r};
  endfunction

  logic [32:0] alu_out;
  assign alu_out      = alu_fn(alu_a, alu_b, alu_ctr);
  assign alu_result   = alu_out[31:0];
  assign alu_overflow = alu_out[32];
  assign alu_zero     = (alu_out[31:0] == 32'd0);

  typedef struct {
    logic [2:0]  ctr;
    logic [31:0] b;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        zero;
    logic        ill;
    logic        trap;
    logic        beq;
  } exp_t;

  // Reference model: instruction semantics straight from the ISA rules.
  function automatic exp_t ref_model(input logic [31:0] ins, a, b);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic [31:0] opb;
    longint s;
    int kind;   // 0 add 1 addu 2 sub 3 subu 4 or 5 slt 6 sltu, -1 illegal
    bit ovf;
    op = ins[31:26];
    fn = ins[5:0];
    e.ctr = 3'd0; e.b = 32'd0; e.data = 32'd0; e.rd = 5'd0;
    e.we = 1'b0; e.zero = 1'b0; e.ill = 1'b0; e.trap = 1'b0; e.beq = 1'b0;
    kind = -1;
    opb = b;
    if (op == 6'd0) begin
      e.rd = ins[15:11];
      case (fn)
        6'h20: kind = 0;
        6'h21: kind = 1;
        6'h22: kind = 2;
        6'h23: kind = 3;
        6'h25: kind = 4;
        6'h2a: kind = 5;
        6'h2b: kind = 6;
        default: kind = -1;
      endcase
    end else if (op == 6'h04) begin
      kind = 3;
      e.beq = 1'b1;
    end else begin
      e.rd = ins[20:16];
      opb = {{16{ins[15]}}, ins[15:0]};
      case (op)
        6'h08: kind = 0;
        6'h09: kind = 1;
        6'h0a: kind = 5;
        6'h0b: kind = 6;
        6'h0d: begin kind = 4; opb = {16'd0, ins[15:0]}; end
        default: kind = -1;
      endcase
    end
    if (kind < 0) begin
      e.ill = 1'b1;
      return e;
    end
    ovf = 1'b0;
    case (kind)
      0: begin e.ctr = 3'b001; s = longint'($signed(a)) + longint'($signed(opb)); e.data = s[31:0]; ovf = (s > MAXI) || (s < MINI); end
      1: begin e.ctr = 3'b000; e.data = a + opb; end
      2: begin e.ctr = 3'b101; s = longint'($signed(a)) - longint'($signed(opb)); e.data = s[31:0]; ovf = (s > MAXI) || (s < MINI); end
      3: begin e.ctr = 3'b100; e.data = a - opb; end
      4: begin e.ctr = 3'b010; e.data = a | opb; end
      5: begin e.ctr = 3'b111; e.data = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0; end
      default: begin e.ctr = 3'b110; e.data = (a < opb) ? 32'd1 : 32'd0; end
    endcase
    e.b    = opb;
    e.zero = (e.data == 32'd0);
    e.trap = TRAP_EN && ovf;
    e.we   = !e.beq && (e.rd != 5'd0) && !e.trap;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd);
    return {6'd0, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  // Issue one op, check timing, hold the result `hold` cycles, then retire it.
  task automatic do_op(input logic [31:0] ins, a, b, input int hold);
    exp_t e;
    int lat;
    e = ref_model(ins, a, b);
    @(negedge clk);
    chk("instr_ready_idle", instr_ready, 1'b1);
    instr_valid = 1'b1; instr = ins; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    // Keep offering junk while busy; it must be ignored.
    instr = $urandom; rs_data = $urandom; rt_data = $urandom;
    if (!e.ill) begin
      chk("alu_ctr", alu_ctr, e.ctr);
      chk("alu_a", alu_a, a);
      chk("alu_b", alu_b, e.b);
    end
    lat = e.ill ? 0 : E;
    for (int k = 0; k < lat; k++) begin
      chk("res_valid_early", res_valid, 1'b0);
      chk("instr_ready_busy", instr_ready, 1'b0);
      res_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    chk("res_valid", res_valid, 1'b1);
    chk("res_illegal", res_illegal, e.ill);
    chk("res_data", res_data, e.data);
    chk("res_we", res_we, e.we);
    if (!e.ill) begin
      chk("res_trap", res_trap, e.trap);
      chk("res_zero", res_zero, e.zero);
      if (!e.beq) chk("res_rd", res_rd, e.rd);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_data", res_data, e.data);
      chk("hold_ready", instr_ready, 1'b0);
      if (!e.ill) chk("hold_alu_a", alu_a, a);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    instr_valid = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("op_cnt", op_cnt, exp_cnt);
    chk("res_valid_retired", res_valid, 1'b0);
    chk("instr_ready_after", instr_ready, 1'b1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] r_fn [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h25, 6'h2a, 6'h2b};
    logic [5:0] i_op [5] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0d};
    logic [4:0] rd;
    int k;
    rd = 5'($urandom);
    k  = $urandom_range(0, 13);
    if (k < 7)       return rtype(r_fn[k], rd);
    else if (k < 12) return itype(i_op[k-7], rd, 16'($urandom));
    else if (k == 12) return {6'h04, 5'd1, 5'd2, 16'($urandom)};
    else             return ($urandom_range(0, 1) == 0) ? {6'h3f, 26'($urandom)} : rtype(6'h00, rd);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ri;
    #23;
    chk("rst_instr_ready", instr_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_op_cnt", op_cnt, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", instr_ready, 1'b1);

    do_op(rtype(6'h20, 5'd3), 32'd5, 32'd7, 0);                      // add 5+7
    do_op(itype(6'h08, 5'd4, 16'h0001), 32'h7FFF_FFFF, 32'd0, 0);     // addi overflow
    do_op(itype(6'h0a, 5'd5, 16'h0000), 32'hFFFF_FFFF, 32'd0, 0);     // slti -1 < 0
    do_op(itype(6'h0b, 5'd6, 16'h0000), 32'hFFFF_FFFF, 32'd0, 0);     // sltiu
    do_op(itype(6'h0d, 5'd7, 16'h8000), 32'd0, 32'd0, 0);             // ori zero-ext
    do_op({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1234, 0);      // beq taken
    do_op({6'h3f, 26'h0}, 32'hDEAD, 32'hBEEF, 0);                     // illegal opcode
    do_op(rtype(6'h22, 5'd9), 32'h8000_0000, 32'd1, 5);               // sub overflow, stall
    do_op(rtype(6'h21, 5'd0), 32'd1, 32'd2, 2);                       // rd=0 no write

    // Reset in the middle of EXEC drops the op.
    @(negedge clk);
    instr_valid = 1'b1; instr = rtype(6'h20, 5'd8); rs_data = 32'd11; rt_data = 32'd22;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", res_valid, 1'b0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_ctr", alu_ctr, 3'd0);
    chk("mid_rst_opcnt", op_cnt, 0);
    chk("mid_rst_data", res_data, 32'd0);
    chk("mid_rst_ready", instr_ready, 1'b0);
    @(negedge clk); rst = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;
    chk("rel_ready", instr_ready, 1'b1);
    chk("rel_valid", res_valid, 1'b0);

    // Random traffic; more than 2^CW ops so op_cnt wraps.
    for (int n = 0; n < 40; n++) begin
      ri = rand_instr();
      do_op(ri, pick_operand(), pick_operand(), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
